// File: rtl/xor_share_sched.sv
// Round-robin scheduler that time-shares one external 2-input XOR cell among
// NREQ requesters, serially reducing each granted W-bit word to its parity.
module xor_share_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*W-1:0]         data,
    output logic [NREQ-1:0]           grant,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NREQ)-1:0]   done_id,
    output logic                      parity,
    output logic                      xor_a,
    output logic                      xor_b,
    input  logic                      xor_z
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t                  r_state, w_next;
    logic [IW-1:0]           r_ptr, r_win, w_win;
    logic [NREQ-1:0]         r_grant;
    logic [W-1:0]            r_sh;
    logic [CW-1:0]           r_cnt;
    logic                    r_acc, r_par;
    logic                    w_found, w_last;
    logic [NREQ-1:0][W-1:0]  w_words;
    int                      v_idx;

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign w_words[g] = data[g*W +: W];
    end

    assign w_last = (r_cnt == CW'(W-1));

    // First requester at or after ptr+1, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        v_idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            v_idx = int'(r_ptr) + i;
            if (v_idx >= NREQ) v_idx = v_idx - NREQ;
            if (!w_found && req[v_idx]) begin
                w_found = 1'b1;
                w_win   = IW'(v_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_SHIFT;
            S_SHIFT: if (w_last)  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        xor_a = 1'b0;
        xor_b = 1'b0;
        done  = 1'b0;
        busy  = (r_state != S_IDLE);
        case (r_state)
            S_SHIFT: begin
                xor_a = r_acc;
                xor_b = r_sh[0];
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= IW'(NREQ-1);
            r_win   <= '0;
            r_grant <= '0;
            r_sh    <= '0;
            r_cnt   <= '0;
            r_acc   <= 1'b0;
            r_par   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_found) begin
                    r_sh    <= w_words[w_win];
                    r_acc   <= 1'b0;
                    r_cnt   <= '0;
                    r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                    r_ptr   <= w_win;
                    r_win   <= w_win;
                end
                S_SHIFT: begin
                    r_acc <= xor_z;
                    r_sh  <= r_sh >> 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) r_par <= xor_z;
                end
                S_DONE:  r_grant <= '0;
                default: ;
            endcase
        end
    end

    assign grant   = r_grant;
    assign done_id = r_win;
    assign parity  = r_par;
endmodule

// File: tb/tb_xor_share_sched.sv
// Randomized scoreboard bench for xor_share_sched: a cycle-count reference
// model predicts grants and parities; a negedge monitor checks the DUT.
module tb_xor_share_sched;
    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] data = '0;
    logic [NREQ-1:0]   grant;
    logic              busy, done, parity, xor_a, xor_b, xor_z;
    logic [1:0]        done_id;

    xor_share_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .grant(grant),
        .busy(busy), .done(done), .done_id(done_id), .parity(parity),
        .xor_a(xor_a), .xor_b(xor_b), .xor_z(xor_z)
    );

    // The external shared cell.
    assign xor_z = xor_a ^ xor_b;

    always #5 clk = ~clk;

    typedef struct {int id; bit par;} exp_t;
    exp_t sbq[$];

    int  checks = 0;
    int  errors = 0;
    int  rem    = 0;      // cycles the current service still owns the cell
    int  m_ptr  = NREQ-1;
    int  m_k    = 0;
    bit  m_par  = 1'b0;
    bit  mon_en = 1'b0;
    bit  gap_chk = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one service occupies W+1 cycles, then one idle cycle.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            rem = 0; m_ptr = NREQ-1; m_par = 1'b0;
            sbq.delete();
        end else if (rem > 0) begin
            rem--;
            if (rem == 1 && sbq.size() > 0) m_par = sbq[0].par;
        end else if (req != '0) begin
            for (int i = 1; i <= NREQ; i++) begin
                int k;
                k = (m_ptr + i) % NREQ;
                if (req[k]) begin
                    logic [W-1:0] wd;
                    exp_t e;
                    wd = data[k*W +: W];
                    e.id = k;
                    e.par = ($countones(wd) % 2) == 1;
                    sbq.push_back(e);
                    m_k = k; m_ptr = k; rem = W+1;
                    break;
                end
            end
        end
    end

    // Monitor
    initial begin
        int cyc = 0, last_done = 0;
        bit prev_in = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                logic [NREQ-1:0] eg;
                eg = (rem > 0) ? (NREQ'(1) << m_k) : '0;
                chk("grant", grant, eg);
                chk("busy", busy, rem > 0);
                chk("done", done, rem == 1);
                if (rem <= 1) chk("xor_ab_idle", {xor_a, xor_b}, 0);
                if (done) begin
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL done_unexpected: got done=1 expected no pending result");
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("done_id", done_id, e.id);
                        chk("parity_done", parity, e.par);
                    end
                    if (gap_chk && prev_in) chk("done_spacing", cyc - last_done, W+2);
                    prev_in = gap_chk;
                    last_done = cyc;
                end else begin
                    chk("parity_hold", parity, m_par);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_parity", parity, 0);
        mon_en = 1'b1;

        // Single requester, odd word
        req = 4'b0001; data = '0; data[7:0] = 8'hB5;
        tick(1); req = '0; tick(W+3);

        // Even word on requester 2
        req = 4'b0100; data[23:16] = 8'h3C;
        tick(1); req = '0; tick(W+4);

        // Round-robin from fresh reset, spacing checked
        do_reset();
        data = {8'h0F, 8'h07, 8'h03, 8'h01};
        gap_chk = 1'b1;
        req = 4'b1111;
        tick(4*(W+2)+1);
        req = '0; tick(W+3);
        gap_chk = 1'b0;

        // Drop request and corrupt data right after the grant edge
        req = 4'b0010; data[15:8] = 8'hFF;
        tick(1);
        req = '0; data = '0;
        tick(W+3);

        // Wrap priority: serve 3, then 1001 -> 0 then 3
        req = 4'b1000; data[31:24] = 8'h01;
        tick(1); req = '0; tick(W+3);
        req = 4'b1001;
        tick(W+3);
        req = '0; tick(W+3);

        // Reset during the 4th SHIFT cycle
        req = 4'b0100; data[23:16] = 8'h01;
        tick(1); req = '0;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_grant", grant, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_parity", parity, 0);
        chk("midrst_done", done, 0);
        req = 4'b0010; data[15:8] = 8'h07;
        tick(1); req = '0; tick(W+3);

        // Random traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            req  = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if ($urandom_range(0, 3) == 0) req = '0;
            data = {$urandom()};
            rst  = ($urandom_range(0, 149) == 0);
            tick(1);
        end
        rst = 1'b0; req = '0;
        tick(W+4);
        chk("drain_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
